fb_row_arbiter: RTL and testbench

Arbitrates the single-port 40x30 1bpp framebuffer between three requesters: the display row fetch from the VGA renderer, host row writes from the MCU link, and an internal clear engine. The display fetch always wins and has a fixed latency, so pixel generation never stalls. The two writers share the remaining slots round-robin and can optionally be restricted to vertical blanking to avoid tearing. The block sits between the MCU interface and the renderer that feeds `pixel_value_next` to `vga_controller`.

---
 rtl/fb_pkg.sv | 22 ++
 rtl/fb_row_ram.sv | 35 +++
 rtl/fb_row_arbiter.sv | 142 ++++++++++++++
 tb/tb_fb_row_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and geometry for the 40x30 1bpp framebuffer arbiter.
// Row width, row count and the grant/clear-state encodings live here.
package fb_pkg;

  localparam int SRC_W = 40;
  localparam int SRC_H = 30;
  localparam int ROW_W = 5;

  typedef logic [SRC_W-1:0] fb_row_t;

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_t;

  typedef enum logic [1:0] {
    G_NONE,
    G_HOST,
    G_CLEAR
  } grant_t;

endpackage

// File: rtl/fb_row_ram.sv
// Single-port framebuffer row RAM with synchronous read and per-bit write enable.
// There is no reset and no initial contents, so it maps onto block RAM.
module fb_row_ram #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 30,
  parameter int AW    = 5
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [WIDTH-1:0] i_bit_en,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // A write takes the single port; otherwise a read may use it.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (i_bit_en[b]) begin
          r_mem[i_addr][b] <= i_wdata[b];
        end
      end
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fb_row_arbiter.sv
// Framebuffer port arbiter: display fetch has absolute priority with a fixed
// two-cycle latency; host writes and the clear engine share leftover slots round-robin.
module fb_row_arbiter
  import fb_pkg::*;
#(
  parameter int SRC_W       = fb_pkg::SRC_W,
  parameter int SRC_H       = fb_pkg::SRC_H,
  parameter int VBLANK_ONLY = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_rd_req,
  input  logic [ROW_W-1:0] i_rd_row,
  output logic             o_rd_valid,
  output logic [SRC_W-1:0] o_rd_data,
  input  logic             i_in_vblank,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [ROW_W-1:0] i_wr_row,
  input  logic [SRC_W-1:0] i_wr_data,
  input  logic [SRC_W-1:0] i_wr_mask,
  input  logic             i_clear_start,
  input  logic             i_clear_value,
  output logic             o_clear_busy,
  output logic             o_err_row
);

  clr_state_t       r_state, w_state_next;
  logic [ROW_W-1:0] r_row_ctr, w_row_ctr_next;
  logic             r_clr_val, w_clr_val_next;
  grant_t           r_last_grant, w_grant;
  logic             r_err_row;
  logic             r_rd_v1, r_rd_oob1, r_rd_valid;
  logic [SRC_W-1:0] r_rd_data;

  logic             w_slot_open, w_host_oob, w_rd_oob;
  logic             w_ram_we, w_ram_re;
  logic [ROW_W-1:0] w_ram_addr;
  logic [SRC_W-1:0] w_ram_wdata, w_ram_mask, w_ram_rdata;

  assign w_slot_open = !i_reset && !i_rd_req && ((VBLANK_ONLY == 0) || i_in_vblank);
  assign w_host_oob  = int'(i_wr_row) >= SRC_H;
  assign w_rd_oob    = int'(i_rd_row) >= SRC_H;

  // On contention the writer that did not win last time takes the slot.
  always_comb begin
    w_grant = G_NONE;
    if (w_slot_open) begin
      if (i_wr_valid && (r_state == CLEAR)) begin
        w_grant = (r_last_grant == G_HOST) ? G_CLEAR : G_HOST;
      end else if (i_wr_valid) begin
        w_grant = G_HOST;
      end else if (r_state == CLEAR) begin
        w_grant = G_CLEAR;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_row_ctr_next = r_row_ctr;
    w_clr_val_next = r_clr_val;
    case (r_state)
      IDLE: begin
        if (i_clear_start) begin
          w_state_next   = CLEAR;
          w_row_ctr_next = '0;
          w_clr_val_next = i_clear_value;
        end
      end
      CLEAR: begin
        if (w_grant == G_CLEAR) begin
          if (r_row_ctr == ROW_W'(SRC_H - 1)) begin
            w_state_next   = IDLE;
            w_row_ctr_next = '0;
          end else begin
            w_row_ctr_next = r_row_ctr + 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_ram_we    = (w_grant == G_CLEAR) || ((w_grant == G_HOST) && !w_host_oob);
  assign w_ram_re    = i_rd_req && !w_rd_oob;
  assign w_ram_addr  = i_rd_req ? i_rd_row : ((w_grant == G_CLEAR) ? r_row_ctr : i_wr_row);
  assign w_ram_wdata = (w_grant == G_CLEAR) ? {SRC_W{r_clr_val}} : i_wr_data;
  assign w_ram_mask  = (w_grant == G_CLEAR) ? {SRC_W{1'b1}} : i_wr_mask;

  fb_row_ram #(
    .WIDTH (SRC_W),
    .DEPTH (SRC_H),
    .AW    (ROW_W)
  ) u_ram (
    .i_clk    (i_clk),
    .i_we     (w_ram_we),
    .i_re     (w_ram_re),
    .i_addr   (w_ram_addr),
    .i_wdata  (w_ram_wdata),
    .i_bit_en (w_ram_mask),
    .o_rdata  (w_ram_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_row_ctr    <= '0;
      r_clr_val    <= 1'b0;
      r_last_grant <= G_CLEAR;
      r_err_row    <= 1'b0;
      r_rd_v1      <= 1'b0;
      r_rd_oob1    <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_row_ctr <= w_row_ctr_next;
      r_clr_val <= w_clr_val_next;
      if (w_grant != G_NONE) begin
        r_last_grant <= w_grant;
      end
      if (((w_grant == G_HOST) && w_host_oob) || (i_rd_req && w_rd_oob)) begin
        r_err_row <= 1'b1;
      end
      r_rd_v1    <= i_rd_req;
      r_rd_oob1  <= w_rd_oob;
      r_rd_valid <= r_rd_v1;
      // Out-of-range fetches never touched the RAM, so substitute zeros.
      if (r_rd_v1) begin
        r_rd_data <= r_rd_oob1 ? '0 : w_ram_rdata;
      end
    end
  end

  assign o_wr_ready   = (w_grant == G_HOST);
  assign o_clear_busy = (r_state == CLEAR);
  assign o_err_row    = r_err_row;
  assign o_rd_valid   = r_rd_valid;
  assign o_rd_data    = r_rd_data;

endmodule

// File: tb/tb_fb_row_arbiter.sv
// Scoreboard bench for fb_row_arbiter: directed scenarios followed by random traffic,
// all checked against a row-array reference model of the framebuffer.
module tb_fb_row_arbiter;

  localparam int W = 40;
  localparam int H = 30;

  logic         clk = 1'b0;
  logic         reset;
  logic         rdReq;
  logic [4:0]   rdRow;
  logic         rdValid;
  logic [W-1:0] rdData;
  logic         inVblank;
  logic         wrValid;
  logic         wrReady;
  logic [4:0]   wrRow;
  logic [W-1:0] wrData;
  logic [W-1:0] wrMask;
  logic         clearStart;
  logic         clearValue;
  logic         clearBusy;
  logic         errRow;

  fb_row_arbiter dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_rd_req      (rdReq),
    .i_rd_row      (rdRow),
    .o_rd_valid    (rdValid),
    .o_rd_data     (rdData),
    .i_in_vblank   (inVblank),
    .i_wr_valid    (wrValid),
    .o_wr_ready    (wrReady),
    .i_wr_row      (wrRow),
    .i_wr_data     (wrData),
    .i_wr_mask     (wrMask),
    .i_clear_start (clearStart),
    .i_clear_value (clearValue),
    .o_clear_busy  (clearBusy),
    .o_err_row     (errRow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } rdExp_t;

  rdExp_t       expQ[$];
  logic [W-1:0] model [H];
  bit           mBusy     = 1'b0;
  bit           mLastHost = 1'b0;
  bit           mErr      = 1'b0;
  bit           mClrVal   = 1'b0;
  int           mCtr      = 0;
  int           cyc       = 0;
  int           errors    = 0;
  int           checks    = 0;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare outputs against the model, then advance the model across the coming edge.
  always @(negedge clk) begin : monitor
    bit     slot, hostG, clrG, busyOld;
    rdExp_t e;
    cyc++;
    slot  = !reset && !rdReq && inVblank;
    hostG = 1'b0;
    clrG  = 1'b0;
    if (slot) begin
      if (wrValid && mBusy) begin
        hostG = !mLastHost;
        clrG  = mLastHost;
      end else begin
        hostG = wrValid;
        clrG  = mBusy;
      end
    end
    checkOutput("wr_ready", W'(wrReady), W'(hostG));
    checkOutput("clear_busy", W'(clearBusy), W'(mBusy));
    checkOutput("err_row", W'(errRow), W'(mErr));

    if (rdValid === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rd_unexpected cycle %0d: got rd_valid=1 data %h expected no read", cyc, rdData);
      end else begin
        e = expQ.pop_front();
        checkOutput("rd_latency", W'(cyc), W'(e.due));
        checkOutput("rd_data", rdData, e.data);
      end
    end else if (expQ.size() > 0 && expQ[0].due <= cyc) begin
      checks++;
      errors++;
      $display("[TB] FAIL rd_missing cycle %0d: got rd_valid=%b expected 1", cyc, rdValid);
      void'(expQ.pop_front());
    end

    if (reset) begin
      mBusy     = 1'b0;
      mCtr      = 0;
      mLastHost = 1'b0;
      mErr      = 1'b0;
      expQ.delete();
    end else begin
      busyOld = mBusy;
      if (hostG) begin
        mLastHost = 1'b1;
        if (wrRow < H) model[wrRow] = (model[wrRow] & ~wrMask) | (wrData & wrMask);
        else mErr = 1'b1;
      end
      if (clrG) begin
        mLastHost   = 1'b0;
        model[mCtr] = {W{mClrVal}};
        if (mCtr == H - 1) begin
          mBusy = 1'b0;
          mCtr  = 0;
        end else begin
          mCtr++;
        end
      end
      if (!busyOld && clearStart) begin
        mBusy   = 1'b1;
        mCtr    = 0;
        mClrVal = clearValue;
      end
      if (rdReq) begin
        e.due  = cyc + 2;
        e.data = (rdRow < H) ? model[rdRow] : '0;
        if (rdRow >= H) mErr = 1'b1;
        expQ.push_back(e);
      end
    end
  end

  task automatic applyStimulus(input bit rd, input int rrow, input bit wv, input int wrow,
                               input logic [W-1:0] wd, input logic [W-1:0] wm,
                               input bit vb, input bit cs, input bit cv);
    rdReq      = rd;
    rdRow      = 5'(rrow);
    wrValid    = wv;
    wrRow      = 5'(wrow);
    wrData     = wd;
    wrMask     = wm;
    inVblank   = vb;
    clearStart = cs;
    clearValue = cv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, '0, '0, 1, 0, 0);
  endtask

  task automatic readRow(input int r);
    applyStimulus(1, r, 0, 0, '0, '0, 1, 0, 0);
  endtask

  task automatic writeRow(input int r, input logic [W-1:0] d, input logic [W-1:0] m);
    applyStimulus(0, 0, 1, r, d, m, 1, 0, 0);
  endtask

  function automatic logic [W-1:0] randWord();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[W-1:0];
  endfunction

  // Keep the host streaming to row 29 until the clear engine finishes or the budget runs out.
  task automatic waitClear(input int bound, input bit hostStream);
    int k;
    k = 0;
    while (clearBusy && k < bound) begin
      applyStimulus(0, 0, hostStream, 29, randWord(), '1, 1, 0, 0);
      k++;
    end
    checks++;
    if (k >= bound) begin
      errors++;
      $display("[TB] FAIL clear_timeout: clear_busy still %b after %0d cycles, expected 0", clearBusy, bound);
    end
  endtask

  initial begin
    reset = 1'b1;
    rdReq = 0; rdRow = 0; wrValid = 0; wrRow = 0; wrData = '0; wrMask = '0;
    inVblank = 0; clearStart = 0; clearValue = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rd_valid", W'(rdValid), '0);
    checkOutput("reset_rd_data", rdData, '0);
    checkOutput("reset_wr_ready", W'(wrReady), '0);
    checkOutput("reset_clear_busy", W'(clearBusy), '0);
    checkOutput("reset_err_row", W'(errRow), '0);
    reset = 1'b0;

    $display("[TB] initial clear to zero");
    applyStimulus(0, 0, 0, 0, '0, '0, 1, 1, 0);
    waitClear(200, 0);

    $display("[TB] read latency");
    writeRow(5, 40'h00_FF00_FF00, '1);
    readRow(5);
    idle(3);

    $display("[TB] masked write");
    writeRow(3, 40'hFF_FFFF_FFFF, '1);
    writeRow(3, 40'h0, 40'h00_0000_00FF);
    readRow(3);
    idle(3);

    $display("[TB] display priority");
    for (int i = 0; i < 10; i++) applyStimulus(1, i, 1, 10, 40'h12_3456_789A, '1, 1, 0, 0);
    applyStimulus(0, 0, 1, 10, 40'h12_3456_789A, '1, 1, 0, 0);
    readRow(10);
    idle(3);

    $display("[TB] vblank gating");
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 7, 40'hA5_A5A5_A5A5, '1, 0, 0, 0);
    applyStimulus(0, 0, 1, 7, 40'hA5_A5A5_A5A5, '1, 1, 0, 0);
    readRow(7);
    idle(3);

    $display("[TB] clear with host contention");
    applyStimulus(0, 0, 1, 29, randWord(), '1, 1, 1, 1);
    waitClear(200, 1);
    for (int r = 0; r < H; r++) readRow(r);
    idle(3);

    $display("[TB] out-of-range row");
    writeRow(31, 40'hDE_ADBE_EF00, '1);
    readRow(31);
    readRow(0);
    idle(3);

    $display("[TB] reset during clear");
    applyStimulus(0, 0, 0, 0, '0, '0, 1, 1, 0);
    idle(5);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    checkOutput("midclear_busy", W'(clearBusy), '0);
    checkOutput("midclear_err_row", W'(errRow), '0);
    for (int r = 0; r < 8; r++) readRow(r);
    idle(3);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom % 3) == 0, $urandom_range(0, 31),
                    ($urandom % 2) == 0,
                    (($urandom % 16) == 0) ? $urandom_range(30, 31) : $urandom_range(0, 29),
                    randWord(), randWord(),
                    ($urandom % 4) != 0, ($urandom % 100) == 0, ($urandom % 2) == 0);
    end
    idle(5);
    checkOutput("reads_drained", W'(expQ.size()), '0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
